rp_8bit_irq_ctl: RTL and testbench
==================================

// Module: rp_8bit_irq_ctl
// PURPOSE
//  Interrupt controller for the rp_8bit core: collects IRW peripheral sources, latches them as pending,
//  masks with software enables, picks the highest priority and presents a stable one-hot irq_req to
//  the core until irq_ack. Software-visible registers sit on the core I/O bus (io_*), next to the
//  other I/O peripherals.
// PARAMETERS
//  IRW   8      number of interrupt lines (2..8); index 0 = highest priority
//  BASE  6'h38  I/O address of register 0; registers occupy BASE..BASE+3 (BASE+3 <= 63)
// PORTS
//  clk      in   1    clock
//  rst      in   1    reset, asynchronous, active-high
//  io_wen   in   1    I/O write enable
//  io_ren   in   1    I/O read enable
//  io_adr   in   6    I/O address
//  io_wdt   in   8    I/O write data
//  io_msk   in   8    I/O write bit mask (1 = bit written)
//  io_rdt   out  8    I/O read data, registered
//  src      in   IRW  peripheral interrupt sources, synchronous to clk
//  irq_req  out  IRW  one-hot interrupt request to core, registered
//  irq_ack  in   IRW  one-hot acknowledge from core, single-cycle pulse
// BEHAVIOUR
//  Reset: IE=IP=EDG=CTL=0, prev src=0, io_rdt=0, irq_req=0, FSM=IDLE.
//  Registers (offset from BASE; only masked bits written; bits >= IRW read 0):
//   +0 IE   R/W  per-line enable
//   +1 IP   R/W1C pending; software writing 1 clears, writing 0 no effect
//   +2 EDG  R/W  1 = rising-edge sensitive, 0 = level sensitive
//   +3 CTL  [0] GIE R/W; [1] ERR R/W1C sticky; [6:4] VEC RO current request index; [7] BSY RO (FSM!=IDLE)
//  Read: io_ren at cycle N -> io_rdt valid at N+1, held until next read; other addresses -> 8'h00.
//  Pending set, per line i: EDG[i] ? (src[i] & ~src_q[i]) : src[i]. src_q = src registered.
//  Pending clear: IP W1C, or irq_ack[i] while FSM=REQ and irq_req[i]=1. Set beats clear in same cycle.
//  Candidate: cand = IP & IE & {IRW{GIE}}; winner = lowest set index (sub-module rp_8bit_irq_prio).
//  FSM:
//   IDLE: cand!=0 -> REQ; irq_req <= onehot(winner), VEC <= winner. Visible cycle after cand.
//   REQ : irq_req held stable; a higher-priority cand does not preempt.
//         irq_ack == irq_req -> HOLD; irq_req <= 0; clear that IP bit.
//         irq_ack != 0 and != irq_req -> ERR <= 1, ack ignored, stay REQ.
//         Requested line's IP or IE cleared, or GIE cleared (no ack same cycle) -> IDLE; irq_req <= 0.
//   HOLD: one-cycle gap, irq_req=0; -> IDLE unconditionally (core sees request drop before re-arbitration).
//  irq_ack outside REQ sets ERR. Level line still active after ack re-pends next cycle (expected).
//  Back-to-back requests: minimum 3 cycles ack-to-next-irq_req (HOLD, IDLE, REQ).
//  Reset mid-REQ: irq_req drops asynchronously; all pending state lost.
//  Register write and hardware event on same cycle: hardware set wins for IP; ERR set wins over W1C.
// STRUCTURE
//  Package rp_8bit_irq_pkg: FSM state enum (IDLE, REQ, HOLD), register offsets (OFS_IE/IP/EDG/CTL),
//   CTL bit positions.
//  Sub-module rp_8bit_irq_prio: combinational, IRW-bit vector -> valid, index[2:0], one-hot.
//  Top: register file, edge detect, pending logic, FSM, I/O read mux.
// TESTING
//  1 Reset: after rst, read BASE..BASE+3 -> 00,00,00,00; irq_req=0 throughout.
//  2 Edge: EDG=FF, IE=01, GIE=1; pulse src[0] 1 cycle -> IP=01, irq_req=01 next cycle; ack 01 -> irq_req=0, IP=00.
//  3 Priority/no preempt: IE=FF, src[5] -> irq_req=20; while REQ raise src[1] -> irq_req stays 20;
//    ack 20 -> HOLD, then irq_req=02 three cycles after ack; VEC reads 1.
//  4 Withdraw: in REQ for line 3, write IP=08 (W1C) -> irq_req=0 next cycle, FSM IDLE, BSY=0.
//  5 Bad ack: irq_req=04, drive irq_ack=10 -> ERR=1, irq_req stays 04; write CTL msk=02 wdt=02 -> ERR=0.
//  6 Level & collision: EDG=00, hold src[2]=1, ack -> IP[2] re-sets, irq_req=04 again after HOLD;
//    W1C IP[2] same cycle as edge on line 2 (EDG=04) -> IP[2] stays 1.

Source files
------------

// File: rtl/rp_8bit_irq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rp_8bit_irq_pkg - FSM states, register offsets and CTL bit map of the IRQ controller
// Rev 1.0
// ----------------------------------------------------------------------------
package rp_8bit_irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } irq_state_e;

   localparam logic [1:0] OFS_IE  = 2'd0;
   localparam logic [1:0] OFS_IP  = 2'd1;
   localparam logic [1:0] OFS_EDG = 2'd2;
   localparam logic [1:0] OFS_CTL = 2'd3;

   localparam int CTL_GIE     = 0;
   localparam int CTL_ERR     = 1;
   localparam int CTL_VEC_LSB = 4;
   localparam int CTL_BSY     = 7;

endpackage
`default_nettype wire

// File: rtl/rp_8bit_irq_prio.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rp_8bit_irq_prio - fixed-priority picker, lowest set index wins
// Rev 1.0
// ----------------------------------------------------------------------------
module rp_8bit_irq_prio
   import rp_8bit_irq_pkg::*;
#(
   parameter int IRW = 8
) (
   input  logic [IRW-1:0] vec_i,
   output logic           valid_o,
   output logic [2:0]     idx_o,
   output logic [IRW-1:0] onehot_o
);

   always_comb begin
      idx_o = 3'd0;
      for (int i = IRW - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = 3'(i);
         end
      end
   end

   assign valid_o  = |vec_i;
   // Two's-complement trick isolates the lowest set bit.
   assign onehot_o = vec_i & (~vec_i + IRW'(1));

endmodule
`default_nettype wire

// File: rtl/rp_8bit_irq_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rp_8bit_irq_ctl - pending/enable registers, priority pick and one-hot request handshake
// Rev 1.0
// ----------------------------------------------------------------------------
module rp_8bit_irq_ctl
   import rp_8bit_irq_pkg::*;
#(
   parameter int         IRW  = 8,
   parameter logic [5:0] BASE = 6'h38
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           io_wen,
   input  logic           io_ren,
   input  logic [5:0]     io_adr,
   input  logic [7:0]     io_wdt,
   input  logic [7:0]     io_msk,
   output logic [7:0]     io_rdt,
   input  logic [IRW-1:0] src,
   output logic [IRW-1:0] irq_req,
   input  logic [IRW-1:0] irq_ack
);

   localparam logic [5:0] ADR_IE  = BASE + {4'd0, OFS_IE};
   localparam logic [5:0] ADR_IP  = BASE + {4'd0, OFS_IP};
   localparam logic [5:0] ADR_EDG = BASE + {4'd0, OFS_EDG};
   localparam logic [5:0] ADR_CTL = BASE + {4'd0, OFS_CTL};

   irq_state_e     state_q, state_d;
   logic [IRW-1:0] ie_q, ie_d, ip_q, ip_d, edg_q, edg_d, src_q;
   logic [IRW-1:0] irq_req_q, irq_req_d;
   logic           gie_q, gie_d, err_q, err_d;
   logic [2:0]     vec_q, vec_d;
   logic [7:0]     rdt_q, rdt_d, rd_data;

   logic [IRW-1:0] wmask, wdata, set_vec, sw_clr, hw_clr, cand, win_onehot;
   logic           wr_ie, wr_ip, wr_edg, wr_ctl, ack_ok, ack_bad, win_valid, withdraw;
   logic [2:0]     win_idx;

   assign wr_ie  = io_wen && (io_adr == ADR_IE);
   assign wr_ip  = io_wen && (io_adr == ADR_IP);
   assign wr_edg = io_wen && (io_adr == ADR_EDG);
   assign wr_ctl = io_wen && (io_adr == ADR_CTL);
   assign wmask  = io_msk[IRW-1:0];
   assign wdata  = io_wdt[IRW-1:0];

   assign ie_d  = wr_ie  ? ((ie_q  & ~wmask) | (wdata & wmask)) : ie_q;
   assign edg_d = wr_edg ? ((edg_q & ~wmask) | (wdata & wmask)) : edg_q;
   assign gie_d = (wr_ctl && io_msk[CTL_GIE]) ? io_wdt[CTL_GIE] : gie_q;

   // Hardware set is ORed in last so it beats any clear on the same cycle.
   assign set_vec = (edg_q & src & ~src_q) | (~edg_q & src);
   assign ack_ok  = (state_q == ST_REQ) && (irq_ack == irq_req_q);
   assign ack_bad = (irq_ack != '0) && !ack_ok;
   assign sw_clr  = wr_ip ? (wdata & wmask) : '0;
   assign hw_clr  = ack_ok ? irq_ack : '0;
   assign ip_d    = (ip_q & ~(sw_clr | hw_clr)) | set_vec;
   assign err_d   = ack_bad | (err_q & ~(wr_ctl & io_msk[CTL_ERR] & io_wdt[CTL_ERR]));

   assign cand = ip_q & ie_q & {IRW{gie_q}};

   rp_8bit_irq_prio #(.IRW(IRW)) u_prio (
      .vec_i    (cand),
      .valid_o  (win_valid),
      .idx_o    (win_idx),
      .onehot_o (win_onehot)
   );

   // Withdraw looks at next-state values so a software clear drops the request on the same edge.
   assign withdraw = ((ip_d & irq_req_q) == '0) || ((ie_d & irq_req_q) == '0) || !gie_d;

   always_comb begin
      state_d   = state_q;
      irq_req_d = irq_req_q;
      vec_d     = vec_q;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d   = ST_REQ;
               irq_req_d = win_onehot;
               vec_d     = win_idx;
            end
         end
         ST_REQ: begin
            if (ack_ok) begin
               state_d   = ST_HOLD;
               irq_req_d = '0;
            end else if ((irq_ack == '0) && withdraw) begin
               state_d   = ST_IDLE;
               irq_req_d = '0;
            end
         end
         ST_HOLD: begin
            state_d   = ST_IDLE;
            irq_req_d = '0;
         end
         default: begin
            state_d   = ST_IDLE;
            irq_req_d = '0;
         end
      endcase
   end

   always_comb begin
      rd_data = 8'h00;
      if (io_adr == ADR_IE) begin
         rd_data = 8'(ie_q);
      end else if (io_adr == ADR_IP) begin
         rd_data = 8'(ip_q);
      end else if (io_adr == ADR_EDG) begin
         rd_data = 8'(edg_q);
      end else if (io_adr == ADR_CTL) begin
         rd_data[CTL_GIE]            = gie_q;
         rd_data[CTL_ERR]            = err_q;
         rd_data[CTL_VEC_LSB +: 3]   = vec_q;
         rd_data[CTL_BSY]            = (state_q != ST_IDLE);
      end
   end

   assign rdt_d = io_ren ? rd_data : rdt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ie_q      <= '0;
         ip_q      <= '0;
         edg_q     <= '0;
         src_q     <= '0;
         irq_req_q <= '0;
         gie_q     <= 1'b0;
         err_q     <= 1'b0;
         vec_q     <= 3'd0;
         rdt_q     <= 8'h00;
      end else begin
         state_q   <= state_d;
         ie_q      <= ie_d;
         ip_q      <= ip_d;
         edg_q     <= edg_d;
         src_q     <= src;
         irq_req_q <= irq_req_d;
         gie_q     <= gie_d;
         err_q     <= err_d;
         vec_q     <= vec_d;
         rdt_q     <= rdt_d;
      end
   end

   assign io_rdt  = rdt_q;
   assign irq_req = irq_req_q;

endmodule
`default_nettype wire

// File: tb/tb_rp_8bit_irq_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rp_8bit_irq_ctl - directed scenarios plus random traffic against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rp_8bit_irq_ctl;

   localparam logic [5:0] BASE = 6'h38;

   logic       clk = 1'b0, rst = 1'b0, io_wen = 1'b0, io_ren = 1'b0;
   logic [5:0] io_adr = 6'd0;
   logic [7:0] io_wdt = 8'h00, io_msk = 8'h00, io_rdt;
   logic [7:0] src = 8'h00, irq_req, irq_ack = 8'h00;

   rp_8bit_irq_ctl #(.IRW(8), .BASE(BASE)) dut (
      .clk(clk), .rst(rst), .io_wen(io_wen), .io_ren(io_ren), .io_adr(io_adr),
      .io_wdt(io_wdt), .io_msk(io_msk), .io_rdt(io_rdt), .src(src),
      .irq_req(irq_req), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   // Behavioural model: registers as plain bytes, request tracked as a line number and phase.
   logic [7:0] m_ie, m_ip, m_edg, m_srcq, m_rdt;
   logic       m_gie, m_err;
   int         m_phase, m_line, m_vec;   // phase: 0 idle, 1 requesting, 2 post-ack gap

   task automatic model_reset();
      m_ie = 0; m_ip = 0; m_edg = 0; m_srcq = 0; m_rdt = 0;
      m_gie = 0; m_err = 0; m_phase = 0; m_line = 0; m_vec = 0;
   endtask

   function automatic logic [7:0] model_req();
      return (m_phase == 1) ? 8'(1 << m_line) : 8'h00;
   endfunction

   task automatic step();
      logic [7:0] st, clr, n_ie, n_ip, n_edg, n_rdt, cand, n_srcq;
      logic       n_gie, n_err, ack_ok;
      int         n_phase, n_line, n_vec;
      ack_ok = (m_phase == 1) && (irq_ack == model_req());
      for (int i = 0; i < 8; i++) st[i] = m_edg[i] ? (src[i] & ~m_srcq[i]) : src[i];
      clr = 8'h00;
      if (io_wen && io_adr == BASE + 6'd1) clr = io_wdt & io_msk;
      if (ack_ok) clr = clr | irq_ack;
      n_ip  = (m_ip & ~clr) | st;
      n_ie  = (io_wen && io_adr == BASE)         ? ((m_ie  & ~io_msk) | (io_wdt & io_msk)) : m_ie;
      n_edg = (io_wen && io_adr == BASE + 6'd2)  ? ((m_edg & ~io_msk) | (io_wdt & io_msk)) : m_edg;
      n_gie = (io_wen && io_adr == BASE + 6'd3 && io_msk[0]) ? io_wdt[0] : m_gie;
      n_err = ((irq_ack != 0) && !ack_ok) ||
              (m_err && !(io_wen && io_adr == BASE + 6'd3 && io_msk[1] && io_wdt[1]));
      n_rdt = m_rdt;
      if (io_ren) begin
         if (io_adr == BASE)              n_rdt = m_ie;
         else if (io_adr == BASE + 6'd1)  n_rdt = m_ip;
         else if (io_adr == BASE + 6'd2)  n_rdt = m_edg;
         else if (io_adr == BASE + 6'd3)  n_rdt = {(m_phase != 0), 3'(m_vec), 2'b00, m_err, m_gie};
         else                             n_rdt = 8'h00;
      end
      cand = m_ip & m_ie & {8{m_gie}};
      n_phase = m_phase; n_line = m_line; n_vec = m_vec;
      if (m_phase == 0) begin
         if (cand != 0) begin
            for (int i = 7; i >= 0; i--) if (cand[i]) n_line = i;
            n_phase = 1;
            n_vec   = n_line;
         end
      end else if (m_phase == 1) begin
         if (ack_ok) n_phase = 2;
         else if (irq_ack == 0 && (!n_ip[m_line] || !n_ie[m_line] || !n_gie)) n_phase = 0;
      end else begin
         n_phase = 0;
      end
      n_srcq = src;
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         m_ie = n_ie; m_ip = n_ip; m_edg = n_edg; m_srcq = n_srcq; m_rdt = n_rdt;
         m_gie = n_gie; m_err = n_err; m_phase = n_phase; m_line = n_line; m_vec = n_vec;
      end
   endtask

   task automatic io_write(input logic [5:0] a, input logic [7:0] d, input logic [7:0] m);
      io_wen = 1'b1; io_adr = a; io_wdt = d; io_msk = m;
      step();
      io_wen = 1'b0; io_msk = 8'h00;
   endtask

   task automatic io_read(input logic [5:0] a, output logic [7:0] d);
      io_ren = 1'b1; io_adr = a;
      step();
      io_ren = 1'b0;
      d = io_rdt;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst = 1'b1;
      #1;
      model_reset();
      n_cmp++; if (irq_req !== 8'h00) begin n_bad++; $display("FAIL reset_req: got %02h expected 00", irq_req); end
      n_cmp++; if (io_rdt !== 8'h00) begin n_bad++; $display("FAIL reset_rdt: got %02h expected 00", io_rdt); end
      step(); step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         io_read(BASE + 6'(k), d);
         n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_reg%0d: got %02h expected 00", k, d); end
         n_cmp++; if (irq_req !== 8'h00) begin n_bad++; $display("FAIL reset_req_idle: got %02h expected 00", irq_req); end
      end
   endtask

   task automatic test_edge();
      logic [7:0] d;
      io_write(BASE + 6'd2, 8'hFF, 8'hFF);
      io_write(BASE,        8'h01, 8'hFF);
      io_write(BASE + 6'd3, 8'h01, 8'h01);
      src = 8'h01; step(); src = 8'h00;
      n_cmp++; if (irq_req !== 8'h00) begin n_bad++; $display("FAIL edge_req_early: got %02h expected 00", irq_req); end
      io_read(BASE + 6'd1, d);
      n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL edge_ip_set: got %02h expected 01", d); end
      n_cmp++; if (irq_req !== 8'h01) begin n_bad++; $display("FAIL edge_req: got %02h expected 01", irq_req); end
      irq_ack = 8'h01; step(); irq_ack = 8'h00;
      n_cmp++; if (irq_req !== 8'h00) begin n_bad++; $display("FAIL edge_req_drop: got %02h expected 00", irq_req); end
      io_read(BASE + 6'd1, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL edge_ip_clr: got %02h expected 00", d); end
   endtask

   task automatic test_priority();
      logic [7:0] d;
      io_write(BASE, 8'hFF, 8'hFF);
      src = 8'h20; step(); src = 8'h00; step();
      n_cmp++; if (irq_req !== 8'h20) begin n_bad++; $display("FAIL prio_req5: got %02h expected 20", irq_req); end
      src = 8'h02; step(); src = 8'h00; step();
      n_cmp++; if (irq_req !== 8'h20) begin n_bad++; $display("FAIL prio_no_preempt: got %02h expected 20", irq_req); end
      irq_ack = 8'h20; step(); irq_ack = 8'h00;
      n_cmp++; if (irq_req !== 8'h00) begin n_bad++; $display("FAIL prio_hold: got %02h expected 00", irq_req); end
      step();
      n_cmp++; if (irq_req !== 8'h00) begin n_bad++; $display("FAIL prio_idle: got %02h expected 00", irq_req); end
      step();
      n_cmp++; if (irq_req !== 8'h02) begin n_bad++; $display("FAIL prio_next: got %02h expected 02", irq_req); end
      io_read(BASE + 6'd3, d);
      n_cmp++; if (d !== 8'h91) begin n_bad++; $display("FAIL prio_ctl_vec: got %02h expected 91", d); end
      irq_ack = 8'h02; step(); irq_ack = 8'h00; step(); step();
   endtask

   task automatic test_withdraw();
      logic [7:0] d;
      src = 8'h08; step(); src = 8'h00; step();
      n_cmp++; if (irq_req !== 8'h08) begin n_bad++; $display("FAIL wd_req: got %02h expected 08", irq_req); end
      io_write(BASE + 6'd1, 8'h08, 8'h08);
      n_cmp++; if (irq_req !== 8'h00) begin n_bad++; $display("FAIL wd_drop: got %02h expected 00", irq_req); end
      io_read(BASE + 6'd3, d);
      n_cmp++; if (d !== 8'h31) begin n_bad++; $display("FAIL wd_ctl: got %02h expected 31", d); end
   endtask

   task automatic test_bad_ack();
      logic [7:0] d;
      src = 8'h04; step(); src = 8'h00; step();
      n_cmp++; if (irq_req !== 8'h04) begin n_bad++; $display("FAIL bad_req: got %02h expected 04", irq_req); end
      irq_ack = 8'h10; step(); irq_ack = 8'h00;
      n_cmp++; if (irq_req !== 8'h04) begin n_bad++; $display("FAIL bad_req_held: got %02h expected 04", irq_req); end
      io_read(BASE + 6'd3, d);
      n_cmp++; if (d !== 8'hA3) begin n_bad++; $display("FAIL bad_err_set: got %02h expected A3", d); end
      io_write(BASE + 6'd3, 8'h02, 8'h02);
      io_read(BASE + 6'd3, d);
      n_cmp++; if (d !== 8'hA1) begin n_bad++; $display("FAIL bad_err_clr: got %02h expected A1", d); end
      irq_ack = 8'h04; step(); irq_ack = 8'h00; step(); step();
      n_cmp++; if (irq_req !== 8'h00) begin n_bad++; $display("FAIL bad_final: got %02h expected 00", irq_req); end
   endtask

   task automatic test_level_collision();
      logic [7:0] d;
      io_write(BASE + 6'd2, 8'h00, 8'hFF);
      src = 8'h04; step(); step();
      n_cmp++; if (irq_req !== 8'h04) begin n_bad++; $display("FAIL lvl_req: got %02h expected 04", irq_req); end
      irq_ack = 8'h04; step(); irq_ack = 8'h00; step(); step();
      n_cmp++; if (irq_req !== 8'h04) begin n_bad++; $display("FAIL lvl_repend: got %02h expected 04", irq_req); end
      src = 8'h00; irq_ack = 8'h04; step(); irq_ack = 8'h00; step(); step();
      io_read(BASE + 6'd1, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL lvl_ip_clr: got %02h expected 00", d); end
      io_write(BASE + 6'd3, 8'h00, 8'h01);
      io_write(BASE + 6'd2, 8'h04, 8'hFF);
      src = 8'h04; step(); src = 8'h00; step();
      src = 8'h04; io_write(BASE + 6'd1, 8'h04, 8'h04); src = 8'h00;
      io_read(BASE + 6'd1, d);
      n_cmp++; if (d !== 8'h04) begin n_bad++; $display("FAIL coll_set_wins: got %02h expected 04", d); end
      io_write(BASE + 6'd1, 8'h04, 8'h04);
      io_read(BASE + 6'd1, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL coll_w1c: got %02h expected 00", d); end
      io_write(BASE + 6'd3, 8'h01, 8'h01);
   endtask

   task automatic test_async_reset();
      logic [7:0] d;
      src = 8'h01; step(); src = 8'h00; step();
      n_cmp++; if (irq_req !== 8'h01) begin n_bad++; $display("FAIL arst_req: got %02h expected 01", irq_req); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (irq_req !== 8'h00) begin n_bad++; $display("FAIL arst_drop: got %02h expected 00", irq_req); end
      model_reset();
      step();
      rst = 1'b0;
      io_read(BASE, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL arst_ie: got %02h expected 00", d); end
      io_read(BASE + 6'd3, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL arst_ctl: got %02h expected 00", d); end
   endtask

   task automatic test_random();
      logic [7:0] exp_req;
      io_write(BASE + 6'd3, 8'h01, 8'h01);
      for (int c = 0; c < 800; c++) begin
         src     = 8'($urandom) & 8'($urandom) & 8'($urandom);
         io_wen  = ($urandom_range(0, 5) == 0);
         io_ren  = ($urandom_range(0, 2) == 0);
         io_adr  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : BASE + 6'($urandom_range(0, 3));
         io_wdt  = 8'($urandom);
         io_msk  = 8'($urandom);
         if (io_adr == BASE + 6'd3 && $urandom_range(0, 3) != 0) io_wdt[0] = 1'b1;
         if (m_phase == 1 && $urandom_range(0, 2) == 0) irq_ack = model_req();
         else if ($urandom_range(0, 29) == 0)          irq_ack = 8'(1 << $urandom_range(0, 7));
         else                                           irq_ack = 8'h00;
         step();
         exp_req = model_req();
         n_cmp++; if (irq_req !== exp_req) begin n_bad++; $display("FAIL rnd_req c=%0d: got %02h expected %02h", c, irq_req, exp_req); end
         n_cmp++; if (io_rdt !== m_rdt) begin n_bad++; $display("FAIL rnd_rdt c=%0d: got %02h expected %02h", c, io_rdt, m_rdt); end
      end
      io_wen = 1'b0; io_ren = 1'b0; irq_ack = 8'h00; src = 8'h00;
   endtask

   initial begin
      test_reset();
      test_edge();
      test_priority();
      test_withdraw();
      test_bad_ack();
      test_level_collision();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
